ram_seq_ctrl: RTL and testbench
===============================

RAM_SEQ_CTRL -- requirements
Module: ram_seq_ctrl

Interface
REQ-001 Parameter ADDR_W, default 10, RAM address width.
REQ-002 Parameter WORD_W, default 8, RAM word width.
REQ-003 Parameter DEPTH, default 1024, number of RAM words addressed; DEPTH SHALL equal 2**ADDR_W.
REQ-004 The block SHALL have one clock; reset is synchronous and active-low.
REQ-005 The ports SHALL be, one per line:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  2  00 write, 01 read, 10 fill, 11 check
- cmd_addr  in  ADDR_W  target address for write and read; ignored for fill and check
- cmd_wdata  in  WORD_W  write data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_data  out  WORD_W  read result
- rsp_err_cnt  out  ADDR_W+1  mismatch count from the last check
- busy  out  1  not IDLE
- mem_addr  out  ADDR_W  to RAM addr
- mem_din  out  WORD_W  to RAM data_in
- mem_dout  in  WORD_W  from RAM data_out (asynchronous read)
- mem_wr  out  1  to RAM wr
- mem_cs  out  1  to RAM cs

Function
REQ-006 A command SHALL be accepted on the edge where cmd_valid and cmd_ready are both 1 (edge E0); cmd_valid while busy SHALL be ignored and not queued.
REQ-007 FSM states SHALL be IDLE, ASSERT, RELEASE and DONE; a per-access counter SHALL track the current address.
REQ-008 ASSERT cycle:
- write and fill drive mem_cs=1 and mem_wr=1, with mem_addr and mem_din stable;
- read and check drive mem_cs=1 and mem_wr=0.
REQ-009 RELEASE cycle: mem_wr=0 and mem_cs=0; mem_addr and mem_din SHALL be held from ASSERT.
REQ-010 Read and check SHALL sample mem_dout on the ASSERT->RELEASE edge; read stores the sample into rsp_data.
REQ-011 Single write and single read: ASSERT in cycle 1 after E0, RELEASE in cycle 2, DONE in cycle 3.
REQ-012 Fill: address k = 0..DEPTH-1 in order, ASSERT in cycle 2k+1 and RELEASE in cycle 2k+2, with data (2*k) mod 2**WORD_W.
REQ-013 Fill: DONE SHALL occur in cycle 2*DEPTH+1; the address counter SHALL stop after DEPTH-1 and SHALL NOT wrap.
REQ-014 Check: same address sequence and timing as fill, with reads.
REQ-015 Check: each sample that differs from (2*k) mod 2**WORD_W SHALL increment the error counter; rsp_err_cnt SHALL be cleared at check accept.
REQ-016 Check: the counter holds at most DEPTH, so no saturation logic is needed.
REQ-017 In DONE, rsp_valid SHALL be 1 for exactly one cycle; the next edge returns to IDLE with cmd_ready=1.
REQ-018 rsp_data and rsp_err_cnt SHALL hold their values until overwritten by a later read or check.

Reset
REQ-019 While rst_n=0 at an edge: state IDLE; rsp_valid, busy, mem_wr, mem_cs, mem_addr, mem_din, rsp_data and rsp_err_cnt SHALL be 0; cmd_ready SHALL be 1.
REQ-020 Reset mid-operation SHALL abort the command with no rsp_valid, and SHALL deassert mem_wr and mem_cs at that same edge.

Configuration
REQ-021 Macro RAM_SEQ_CTRL_CHECK_EN defined: check SHALL behave per REQ-014 to REQ-016.
REQ-022 Macro RAM_SEQ_CTRL_CHECK_EN undefined:
- op 11 SHALL go directly from E0 to DONE (rsp_valid in cycle 1);
- no RAM access SHALL occur;
- rsp_err_cnt SHALL stay 0;
- no comparator or counter logic SHALL be synthesised.

Structure
REQ-023 Package ram_seq_pkg SHALL hold the op encoding typedef, the FSM state enum, the default ADDR_W and WORD_W constants, and the fill pattern function.
REQ-024 Sub-module ram_seq_chk (comparator plus error counter) SHALL be instantiated only under RAM_SEQ_CTRL_CHECK_EN.

Verification
REQ-025 Bench SHALL attach a behavioural 1024x8 RAM (async read, write while wr high) and cover:
- Write addr 5 data 0xA5, then read addr 5 -> rsp_data=0xA5; rsp_valid in cycle 3 after each accept.
- Fill -> RAM[200]=144, RAM[1023]=0xFE; rsp_valid in cycle 2049; busy high throughout.
- Fill, then check -> rsp_err_cnt=0; then write addr 10 data 0x00, then check -> rsp_err_cnt=1.
- Read cmd_valid held during fill -> not accepted until cmd_ready; exactly one rsp per accepted command.
- rst_n low 2 cycles at fill cycle 500 -> mem_wr=mem_cs=0 on that edge; no rsp_valid; cmd_ready=1 after release.
- Macro undefined, check op -> rsp_valid in cycle 1; mem_cs never high; rsp_err_cnt=0.

Source files
------------

// File: rtl/ram_seq_pkg.sv
// Shared definitions for the RAM sequencing controller: the command opcode
// encoding, the FSM state encoding, default widths and the fill data pattern.
package ram_seq_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_WORD_W = 8;

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_READ  = 2'b01,
        OP_FILL  = 2'b10,
        OP_CHECK = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_RELEASE = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    // Data written to address k by a fill; callers truncate to their word
    // width, which gives the modulo-2**WORD_W wrap for free.
    function automatic logic [31:0] fill_pattern(input logic [31:0] k);
        return k << 1;
    endfunction

endpackage

// File: rtl/ram_seq_chk.sv
// Check-pass comparator and mismatch counter for ram_seq_ctrl.
// Only compiled when RAM_SEQ_CTRL_CHECK_EN is defined; otherwise this file
// contributes nothing to the build.
`ifdef RAM_SEQ_CTRL_CHECK_EN
module ram_seq_chk #(
    parameter int ADDR_W = 10,
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              sample_en_i,
    input  logic [WORD_W-1:0] sample_i,
    input  logic [WORD_W-1:0] expect_i,
    output logic [ADDR_W:0]   err_cnt_o
);

    logic [ADDR_W:0] err_cnt_q;
    logic [ADDR_W:0] err_cnt_d;

    // Next count: cleared when a check is accepted, bumped on each mismatch.
    // The count can never exceed DEPTH, so it needs no saturation.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (clr_i) begin
            err_cnt_d = '0;
        end else if (sample_en_i && (sample_i != expect_i)) begin
            err_cnt_d = err_cnt_q + (ADDR_W+1)'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt_o = err_cnt_q;

endmodule
`endif

// File: rtl/ram_seq_ctrl.sv
// Command sequencer for an asynchronous-read single-port RAM. Runs single
// writes/reads, a whole-array pattern fill and, when RAM_SEQ_CTRL_CHECK_EN is
// defined, a pattern check that counts mismatching words. Each RAM access is
// a two-cycle ASSERT/RELEASE pair; completion is a one-cycle rsp_valid pulse.
module ram_seq_ctrl
    import ram_seq_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int WORD_W = DEF_WORD_W,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [WORD_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [WORD_W-1:0] rsp_data,
    output logic [ADDR_W:0]   rsp_err_cnt,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_din,
    input  logic [WORD_W-1:0] mem_dout,
    output logic              mem_wr,
    output logic              mem_cs
);

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] din_q, din_d;
    logic [WORD_W-1:0] rsp_data_q, rsp_data_d;

    logic is_seq_op;
    logic is_wr_op;
    logic last_addr;

    assign is_seq_op = (op_q == OP_FILL) || (op_q == OP_CHECK);
    assign is_wr_op  = (op_q == OP_WRITE) || (op_q == OP_FILL);
    // The sweep ends on the final word rather than wrapping back to 0.
    assign last_addr = (addr_q == ADDR_W'(DEPTH - 1));

    // Next-state logic: command decode, address stepping and read capture.
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        addr_d     = addr_q;
        din_d      = din_q;
        rsp_data_d = rsp_data_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d = op_e'(cmd_op);
                    case (op_e'(cmd_op))
                        OP_WRITE, OP_READ: begin
                            addr_d  = cmd_addr;
                            din_d   = cmd_wdata;
                            state_d = ST_ASSERT;
                        end
                        OP_FILL: begin
                            addr_d  = '0;
                            din_d   = WORD_W'(fill_pattern(32'd0));
                            state_d = ST_ASSERT;
                        end
                        default: begin
`ifdef RAM_SEQ_CTRL_CHECK_EN
                            addr_d  = '0;
                            din_d   = WORD_W'(fill_pattern(32'd0));
                            state_d = ST_ASSERT;
`else
                            // Without the checker a check completes at once
                            // and never touches the RAM.
                            state_d = ST_DONE;
`endif
                        end
                    endcase
                end
            end
            ST_ASSERT: begin
                if (op_q == OP_READ) begin
                    rsp_data_d = mem_dout;
                end
                state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (is_seq_op && !last_addr) begin
                    addr_d  = addr_q + ADDR_W'(1);
                    din_d   = WORD_W'(fill_pattern(32'(addr_q) + 32'd1));
                    state_d = ST_ASSERT;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_WRITE;
            addr_q     <= '0;
            din_q      <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    // Strobes decode straight from the state register, so a reset edge drops
    // mem_cs/mem_wr on that same edge.
    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_valid = (state_q == ST_DONE);
    assign mem_cs    = (state_q == ST_ASSERT);
    assign mem_wr    = (state_q == ST_ASSERT) && is_wr_op;
    assign mem_addr  = addr_q;
    assign mem_din   = din_q;
    assign rsp_data  = rsp_data_q;

`ifdef RAM_SEQ_CTRL_CHECK_EN
    logic chk_clr;
    logic chk_sample;

    assign chk_clr    = (state_q == ST_IDLE) && cmd_valid && (op_e'(cmd_op) == OP_CHECK);
    // The expected word is whatever a fill would have driven at this address.
    assign chk_sample = (state_q == ST_ASSERT) && (op_q == OP_CHECK);

    ram_seq_chk #(
        .ADDR_W (ADDR_W),
        .WORD_W (WORD_W)
    ) u_chk (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (chk_clr),
        .sample_en_i (chk_sample),
        .sample_i    (mem_dout),
        .expect_i    (din_q),
        .err_cnt_o   (rsp_err_cnt)
    );
`else
    assign rsp_err_cnt = '0;
`endif

endmodule

// File: tb/tb_ram_seq_ctrl.sv
// Testbench for ram_seq_ctrl: behavioural 1024x8 RAM, directed commands and a
// response scoreboard drained by an independent monitor. Handles both builds
// of RAM_SEQ_CTRL_CHECK_EN.
module tb_ram_seq_ctrl;

    localparam int ADDR_W = 10;
    localparam int WORD_W = 8;
    localparam int DEPTH  = 1024;

    localparam logic [1:0] OP_WR = 2'b00;
    localparam logic [1:0] OP_RD = 2'b01;
    localparam logic [1:0] OP_FL = 2'b10;
    localparam logic [1:0] OP_CK = 2'b11;

    typedef struct {
        int               acc;
        int               lat;
        logic [WORD_W-1:0] data;
        logic [ADDR_W:0]   err;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [WORD_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic [WORD_W-1:0] rsp_data;
    logic [ADDR_W:0]   rsp_err_cnt;
    logic              busy;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_din;
    logic [WORD_W-1:0] mem_dout;
    logic              mem_wr;
    logic              mem_cs;

    logic [WORD_W-1:0] ram [DEPTH];

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   cs_cnt   = 0;

    logic [WORD_W-1:0] hold_data = '0;
    logic [ADDR_W:0]   hold_err  = '0;

    ram_seq_ctrl #(
        .ADDR_W (ADDR_W),
        .WORD_W (WORD_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .rsp_err_cnt (rsp_err_cnt),
        .busy        (busy),
        .mem_addr    (mem_addr),
        .mem_din     (mem_din),
        .mem_dout    (mem_dout),
        .mem_wr      (mem_wr),
        .mem_cs      (mem_cs)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) if (mem_cs === 1'b1) cs_cnt++;

    // Behavioural RAM: asynchronous read, write on the edge while cs and wr.
    assign mem_dout = ram[mem_addr];
    always @(posedge clk) if (mem_cs && mem_wr) ram[mem_addr] <= mem_din;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every completion pulse consumes one expectation, in order.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", 32'(exp_q.size()), 32'd1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rsp_latency", 32'(cyc - e.acc), 32'(e.lat));
                check("rsp_data", 32'(rsp_data), 32'(e.data));
                check("rsp_err_cnt", 32'(rsp_err_cnt), 32'(e.err));
            end
        end
    end

    // Hold cmd_valid until accepted; the expectation is queued with the cycle
    // number that precedes the accepting edge.
    task automatic issue(input logic [1:0] op, input logic [ADDR_W-1:0] addr,
                         input logic [WORD_W-1:0] wd, input int lat, input bit want_rsp);
        int   n = 0;
        exp_t e;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_wdata = wd;
        while (!cmd_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            check("accept_timeout", 32'(cmd_ready), 32'd1);
        end else if (want_rsp) begin
            e.acc  = cyc;
            e.lat  = lat;
            e.data = hold_data;
            e.err  = hold_err;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 32'(cmd_ready), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int bad;
        int cs_before;
        for (int i = 0; i < DEPTH; i++) ram[i] = '0;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_addr  = '0;
        cmd_wdata = '0;

        // Reset state, sampled while reset is still applied.
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_mem_cs", 32'(mem_cs), 32'd0);
        check("rst_mem_wr", 32'(mem_wr), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_din", 32'(mem_din), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_rsp_err_cnt", 32'(rsp_err_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single write then read back; also the top address.
        issue(OP_WR, 10'd5, 8'hA5, 3, 1'b1);
        wait_idle();
        check("ram5_after_write", 32'(ram[5]), 32'hA5);
        hold_data = 8'hA5;
        issue(OP_RD, 10'd5, 8'h00, 3, 1'b1);
        wait_idle();
        issue(OP_WR, 10'd1023, 8'h3C, 3, 1'b1);
        wait_idle();
        hold_data = 8'h3C;
        issue(OP_RD, 10'd1023, 8'h00, 3, 1'b1);
        wait_idle();

        // Fill: busy for cycles 1..2048, completion in cycle 2049.
        issue(OP_FL, 10'd0, 8'h00, 2049, 1'b1);
        bad = 0;
        for (int i = 1; i <= 2048; i++) begin
            @(negedge clk);
            if (busy !== 1'b1) bad++;
        end
        check("busy_during_fill", 32'(bad), 32'd0);
        wait_idle();
        check("fill_ram0", 32'(ram[0]), 32'h00);
        check("fill_ram200", 32'(ram[200]), 32'd144);
        check("fill_ram1023", 32'(ram[1023]), 32'hFE);
        check("fill_ram5", 32'(ram[5]), 32'h0A);

        // Read held high during a fill: accepted only once the fill is done.
        issue(OP_FL, 10'd0, 8'h00, 2049, 1'b1);
        hold_data = 8'd144;
        issue(OP_RD, 10'd200, 8'h00, 3, 1'b1);
        wait_idle();

`ifdef RAM_SEQ_CTRL_CHECK_EN
        hold_err = '0;
        issue(OP_CK, 10'd0, 8'h00, 2049, 1'b1);
        wait_idle();
        issue(OP_WR, 10'd10, 8'h00, 3, 1'b1);
        wait_idle();
        hold_err = 11'd1;
        issue(OP_CK, 10'd0, 8'h00, 2049, 1'b1);
        wait_idle();
`else
        cs_before = cs_cnt;
        issue(OP_CK, 10'd0, 8'h00, 1, 1'b1);
        wait_idle();
        check("check_no_ram_access", 32'(cs_cnt - cs_before), 32'd0);
`endif

        // Reset during a fill at cycle 500 (a RELEASE, k=249).
        issue(OP_FL, 10'd0, 8'h00, 0, 1'b0);
        repeat (500) @(negedge clk);
        check("abort_addr", 32'(mem_addr), 32'd249);
        check("abort_din", 32'(mem_din), 32'd242);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort_mem_wr", 32'(mem_wr), 32'd0);
        check("abort_mem_cs", 32'(mem_cs), 32'd0);
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("post_rst_rsp_data", 32'(rsp_data), 32'd0);
        check("post_rst_err_cnt", 32'(rsp_err_cnt), 32'd0);

        // Controller works again; the aborted fill rewrote address 10.
        hold_data = 8'h14;
        hold_err  = '0;
        issue(OP_RD, 10'd10, 8'h00, 3, 1'b1);
        wait_idle();

        check("all_rsp_seen", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
